// File: rtl/add_serial_pkg.sv
// +--------------------------------------------------------------------+
// | add_serial_pkg : shared FSM encoding and helpers for add_serial_arb|
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package add_serial_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_add_core.sv
// +--------------------------------------------------------------------+
// | serial_add_core : LSB-first bit-serial adder with result register  |
// | Optional carry-out port when ADD_SERIAL_ARB_COUT_EN is defined.     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module serial_add_core
  import add_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             last,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
`ifdef ADD_SERIAL_ARB_COUT_EN
  output logic             cout,
`endif
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_acc_next;

  assign w_sum      = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry    = maj3(r_a[0], r_b[0], r_carry);
  // Each new sum bit enters at the MSB so the LSB-first stream lands in place.
  assign w_acc_next = (r_acc >> 1) | (WIDTH'(w_sum) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
    end else if (load) begin
      r_a     <= opa;
      r_b     <= opb;
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (step) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_acc   <= w_acc_next;
      r_carry <= w_carry;
      if (last) begin
        r_res <= w_acc_next;
      end
    end
  end

  assign res = r_res;

`ifdef ADD_SERIAL_ARB_COUT_EN
  logic r_cout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cout <= 1'b0;
    end else if (step && last) begin
      r_cout <= w_carry;
    end
  end

  assign cout = r_cout;
`endif

endmodule

`default_nettype wire

// File: rtl/add_serial_arb.sv
// +--------------------------------------------------------------------+
// | add_serial_arb : round-robin arbiter sharing one bit-serial adder  |
// | Optional cout port when ADD_SERIAL_ARB_COUT_EN is defined.          |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module add_serial_arb
  import add_serial_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    a,
  input  logic [NREQ*WIDTH-1:0]    b,
  output logic [NREQ-1:0]          ack,
  output logic [WIDTH-1:0]         res,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic                     res_vld,
`ifdef ADD_SERIAL_ARB_COUT_EN
  output logic                     cout,
`endif
  output logic                     busy
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_winner;
  logic [ID_W-1:0]  r_res_id;
  logic [NREQ-1:0]  r_ack;
  logic             r_res_vld;
  logic             w_gnt_vld;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;

  // Scan offsets from far to near so the requester closest after ptr wins.
  always_comb begin : arb
    int idx;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    idx       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (req[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = ID_W'(idx);
      end
    end
  end

  assign w_opa = a[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_opb = b[int'(w_gnt_idx)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          w_load       = 1'b1;
          w_state_next = ST_ADD;
        end
      end
      ST_ADD: begin
        w_step = 1'b1;
        if (r_cnt == C_LAST_CNT) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_ptr     <= ID_W'(NREQ - 1);
      r_winner  <= '0;
      r_res_id  <= '0;
      r_ack     <= '0;
      r_res_vld <= 1'b0;
    end else begin
      r_ack     <= w_load ? (NREQ'(1) << w_gnt_idx) : '0;
      r_res_vld <= w_last;
      if (w_load) begin
        r_winner <= w_gnt_idx;
        r_cnt    <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_res_id <= r_winner;
      end
      if (r_state == ST_DONE) begin
        r_ptr <= r_winner;
      end
    end
  end

  serial_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .step (w_step),
    .last (w_last),
    .opa  (w_opa),
    .opb  (w_opb),
`ifdef ADD_SERIAL_ARB_COUT_EN
    .cout (cout),
`endif
    .res  (res)
  );

  assign ack     = r_ack;
  assign res_id  = r_res_id;
  assign res_vld = r_res_vld;
  assign busy    = (r_state != ST_IDLE);

endmodule

`default_nettype wire
